// File: rtl/gprs_pkg.sv
// Shared types and helpers for the scrubbing GPR file.
// Optional write-first bypass is selected in the top level with macro GPRS_BYPASS_EN.
package gprs_pkg;

  typedef enum logic {
    SCRUB = 1'b0,
    READY = 1'b1
  } gprs_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Preset value written into register idx by the scrub sequencer.
  function automatic int unsigned scrub_val(input int unsigned idx,
                                            input int unsigned preset_cnt,
                                            input int unsigned width);
    int unsigned v;
    v = (idx < preset_cnt) ? (idx + 32'd1) : 32'd0;
    if (width < 32'd32) begin
      v = v & ((32'd1 << width) - 32'd1);
    end else begin
      v = v;
    end
    return v;
  endfunction

endpackage

// File: rtl/gprs_scrub_ctl.sv
// Scrub sequencer: owns the SCRUB/READY FSM, the scrub index, Ready and WrDrop,
// and drives the array's scrub write port one register per cycle.
module gprs_scrub_ctl
  import gprs_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int PRESET_CNT = 8,
  parameter int AW         = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Regwrite_i,
  output logic             scrub_we_o,
  output logic [AW-1:0]    scrub_addr_o,
  output logic [WIDTH-1:0] scrub_data_o,
  output logic             ready_o,
  output logic             wr_drop_o
);

  gprs_state_e    state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic           wr_drop_q, wr_drop_d;

  // State register; Reset is synchronous and handled in the next-state logic.
  always_ff @(posedge Clk) begin
    state_q   <= state_d;
    cnt_q     <= cnt_d;
    wr_drop_q <= wr_drop_d;
  end

  // Next state: one register scrubbed per non-reset edge until DEPTH-1 is written.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_drop_d  = 1'b0;
    scrub_we_o = 1'b0;
    if (Reset) begin
      state_d   = SCRUB;
      cnt_d     = '0;
      wr_drop_d = 1'b0;
    end else begin
      case (state_q)
        SCRUB: begin
          scrub_we_o = 1'b1;
          wr_drop_d  = Regwrite_i;
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_d = READY;
            cnt_d   = cnt_q;
          end else begin
            state_d = SCRUB;
            cnt_d   = cnt_q + AW'(1);
          end
        end
        READY: begin
          state_d   = READY;
          wr_drop_d = 1'b0;
        end
        default: begin
          state_d = SCRUB;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign scrub_addr_o = cnt_q;
  assign scrub_data_o = WIDTH'(scrub_val(32'(cnt_q), 32'(PRESET_CNT), 32'(WIDTH)));
  assign ready_o      = (state_q == READY);
  assign wr_drop_o    = wr_drop_q;

endmodule

// File: rtl/gprs_scrub_rf.sv
// Parametrised GPR file with reset-time scrub sequencer and NRD combinational read ports.
// Define GPRS_BYPASS_EN for write-first bypass; default is read-before-write.
module gprs_scrub_rf
  import gprs_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int NRD        = 2,
  parameter int ZERO_REG   = 1,
  parameter int PRESET_CNT = 8,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Regwrite,
  input  logic [AW-1:0]        A3,
  input  logic [WIDTH-1:0]     Wd,
  input  logic [NRD*AW-1:0]    Ra,
  output logic [NRD*WIDTH-1:0] Rd,
  output logic                 Ready,
  output logic                 WrDrop
);

  logic             scrub_we_s;
  logic [AW-1:0]    scrub_addr_s;
  logic [WIDTH-1:0] scrub_data_s;
  logic             ready_s;
  logic             user_we_s;
  logic             we_s;
  logic [AW-1:0]    waddr_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] mem_q [DEPTH];

  gprs_scrub_ctl #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .PRESET_CNT (PRESET_CNT),
    .AW         (AW)
  ) u_ctl (
    .Clk          (Clk),
    .Reset        (Reset),
    .Regwrite_i   (Regwrite),
    .scrub_we_o   (scrub_we_s),
    .scrub_addr_o (scrub_addr_s),
    .scrub_data_o (scrub_data_s),
    .ready_o      (ready_s),
    .wr_drop_o    (WrDrop)
  );

  assign Ready     = ready_s;
  // Writes to the hardware-zero register are dropped silently, not refused.
  assign user_we_s = ready_s && Regwrite && !Reset &&
                     !((ZERO_REG != 0) && (A3 == AW'(0))) &&
                     (32'(A3) < 32'(DEPTH));

  // Single array write port: scrub owns it while scrubbing, user writes otherwise.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = '0;
    wdata_s = '0;
    if (scrub_we_s) begin
      we_s    = 1'b1;
      waddr_s = scrub_addr_s;
      wdata_s = scrub_data_s;
    end else if (user_we_s) begin
      we_s    = 1'b1;
      waddr_s = A3;
      wdata_s = Wd;
    end else begin
      we_s    = 1'b0;
    end
  end

  // Array storage; contents are deliberately left untouched by Reset.
  always_ff @(posedge Clk) begin
    if (we_s) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    ra_s;
    logic [WIDTH-1:0] rd_s;

    assign ra_s = Ra[k*AW +: AW];

    // Read mux: forced zero while scrubbing or for the hardware-zero register.
    always_comb begin
      rd_s = '0;
      if (!ready_s) begin
        rd_s = '0;
      end else if ((ZERO_REG != 0) && (ra_s == AW'(0))) begin
        rd_s = '0;
`ifdef GPRS_BYPASS_EN
      end else if (user_we_s && (ra_s == A3)) begin
        rd_s = Wd;
`endif
      end else if (32'(ra_s) < 32'(DEPTH)) begin
        rd_s = mem_q[ra_s];
      end else begin
        rd_s = '0;
      end
    end

    assign Rd[k*WIDTH +: WIDTH] = rd_s;
  end

endmodule

// File: tb/tb_gprs_scrub_rf.sv
// Self-checking bench: directed vector table and sequences plus random traffic against a behavioural model.
module tb_gprs_scrub_rf;

`ifdef GPRS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk;
  logic        Reset;
  logic        Regwrite;
  logic [4:0]  A3;
  logic [31:0] Wd;
  logic [4:0]  ra_m [2];
  logic [4:0]  ra_n [3];
  logic [9:0]  ra_vec2;
  logic [14:0] ra_vec3;
  logic [63:0] rd_vec2;
  logic [95:0] rd_vec3;
  logic        rdy2, rdy3, drop2, drop3;

  int errors = 0;
  int checks = 0;

  // behavioural model: array contents, scrub position, status
  logic [31:0] m_z [32];
  logic [31:0] m_n [32];
  bit          mdl_rdy;
  int          mdl_pos;
  bit          mdl_drop;

  assign ra_vec2 = {ra_m[1], ra_m[0]};
  assign ra_vec3 = {ra_n[2], ra_n[1], ra_n[0]};

  gprs_scrub_rf #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1), .PRESET_CNT(8)) dut (
    .Clk(Clk), .Reset(Reset), .Regwrite(Regwrite), .A3(A3), .Wd(Wd),
    .Ra(ra_vec2), .Rd(rd_vec2), .Ready(rdy2), .WrDrop(drop2));

  gprs_scrub_rf #(.WIDTH(32), .DEPTH(32), .NRD(3), .ZERO_REG(0), .PRESET_CNT(8)) dut_n (
    .Clk(Clk), .Reset(Reset), .Regwrite(Regwrite), .A3(A3), .Wd(Wd),
    .Ra(ra_vec3), .Rd(rd_vec3), .Ready(rdy3), .WrDrop(drop3));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input bit zr, input logic [4:0] ra);
    logic [31:0] v;
    if (!mdl_rdy) return 32'd0;
    if (zr && ra == 5'd0) return 32'd0;
    if (BYP && Regwrite && !Reset && ra == A3 && !(zr && A3 == 5'd0)) return Wd;
    v = zr ? m_z[ra] : m_n[ra];
    return v;
  endfunction

  task automatic check_all();
    #1;
    chk("ready", {31'd0, rdy2}, {31'd0, mdl_rdy});
    chk("ready_n", {31'd0, rdy3}, {31'd0, mdl_rdy});
    chk("wrdrop", {31'd0, drop2}, {31'd0, mdl_drop});
    chk("wrdrop_n", {31'd0, drop3}, {31'd0, mdl_drop});
    for (int k = 0; k < 2; k++) chk("rd_z", rd_vec2[k*32 +: 32], exp_rd(1'b1, ra_m[k]));
    for (int k = 0; k < 3; k++) chk("rd_n", rd_vec3[k*32 +: 32], exp_rd(1'b0, ra_n[k]));
  endtask

  // one clock: model follows the rules at the posedge, inputs re-driven after negedge
  task automatic tick();
    @(posedge Clk);
    if (Reset) begin
      mdl_rdy = 1'b0; mdl_pos = 0; mdl_drop = 1'b0;
    end else if (!mdl_rdy) begin
      m_z[mdl_pos] = (mdl_pos < 8) ? 32'(mdl_pos + 1) : 32'd0;
      m_n[mdl_pos] = (mdl_pos < 8) ? 32'(mdl_pos + 1) : 32'd0;
      mdl_pos++;
      mdl_rdy  = (mdl_pos == 32);
      mdl_drop = Regwrite;
    end else begin
      mdl_drop = 1'b0;
      if (Regwrite) begin
        if (A3 != 5'd0) m_z[A3] = Wd;
        m_n[A3] = Wd;
      end
    end
    @(negedge Clk);
  endtask

  task automatic idle_in();
    Reset = 1'b0; Regwrite = 1'b0; A3 = 5'd0; Wd = 32'd0;
    for (int k = 0; k < 2; k++) ra_m[k] = 5'($urandom_range(0, 31));
    for (int k = 0; k < 3; k++) ra_n[k] = 5'($urandom_range(0, 31));
  endtask

  typedef struct {
    logic [4:0]  ra;
    logic [31:0] exp_z;
    logic [31:0] exp_n;
  } rd_vec_t;

  rd_vec_t vt [9];

  initial begin
    vt[0] = '{5'd0,  32'd0, 32'd1};
    vt[1] = '{5'd1,  32'd2, 32'd2};
    vt[2] = '{5'd3,  32'd4, 32'd4};
    vt[3] = '{5'd5,  32'd6, 32'd6};
    vt[4] = '{5'd7,  32'd8, 32'd8};
    vt[5] = '{5'd8,  32'd0, 32'd0};
    vt[6] = '{5'd9,  32'd0, 32'd0};
    vt[7] = '{5'd20, 32'd0, 32'd0};
    vt[8] = '{5'd31, 32'd0, 32'd0};
    for (int i = 0; i < 32; i++) begin m_z[i] = 32'd0; m_n[i] = 32'd0; end
    mdl_rdy = 1'b0; mdl_pos = 0; mdl_drop = 1'b0;

    idle_in();
    @(negedge Clk);
    // Reset for two edges, with a write attempt that must not raise WrDrop
    Reset = 1'b1;
    tick();
    Regwrite = 1'b1; A3 = 5'd4; Wd = 32'h11111111;
    tick();
    check_all();

    // Scrub with a refused write at the 5th scrub edge
    for (int e = 1; e <= 32; e++) begin
      idle_in();
      if (e == 5) begin Regwrite = 1'b1; A3 = 5'd9; Wd = 32'h12345678; end
      check_all();
      tick();
      if (e == 5) chk("wrdrop_pulse", {31'd0, drop2}, 32'd1);
      if (e == 6) chk("wrdrop_one_cycle", {31'd0, drop2}, 32'd0);
      if (e < 32) chk("ready_low_during_scrub", {31'd0, rdy2}, 32'd0);
      else chk("ready_after_32", {31'd0, rdy2}, 32'd1);
    end

    // Post-scrub read table
    idle_in();
    for (int i = 0; i < 9; i++) begin
      ra_m[0] = vt[i].ra; ra_m[1] = vt[i].ra; ra_n[0] = vt[i].ra;
      #1;
      chk("tbl_rd_z0", rd_vec2[31:0], vt[i].exp_z);
      chk("tbl_rd_z1", rd_vec2[63:32], vt[i].exp_z);
      chk("tbl_rd_n", rd_vec3[31:0], vt[i].exp_n);
    end
    @(negedge Clk);

    // Write to reg 5, read in the same and following cycle
    idle_in();
    Regwrite = 1'b1; A3 = 5'd5; Wd = 32'hDEADBEEF; ra_m[0] = 5'd5;
    #1;
    chk("wr5_same_cycle", rd_vec2[31:0], BYP ? 32'hDEADBEEF : 32'd6);
    check_all();
    tick();
    idle_in(); ra_m[0] = 5'd5;
    #1;
    chk("wr5_next_cycle", rd_vec2[31:0], 32'hDEADBEEF);
    @(negedge Clk);

    // Hardware-zero register discards writes
    idle_in();
    Regwrite = 1'b1; A3 = 5'd0; Wd = 32'hFFFFFFFF; ra_m[0] = 5'd0; ra_n[0] = 5'd0;
    check_all();
    tick();
    idle_in(); ra_m[0] = 5'd0; ra_n[0] = 5'd0;
    #1;
    chk("zero_reg_read", rd_vec2[31:0], 32'd0);
    chk("zero_reg_no_drop", {31'd0, drop2}, 32'd0);
    chk("nonzero_cfg_reg0", rd_vec3[31:0], 32'hFFFFFFFF);
    @(negedge Clk);

    // Three ports on the write address
    idle_in();
    Regwrite = 1'b1; A3 = 5'd7; Wd = 32'hA5A5A5A5;
    for (int k = 0; k < 3; k++) ra_n[k] = 5'd7;
    #1;
    for (int k = 0; k < 3; k++) chk("nrd3_before", rd_vec3[k*32 +: 32], BYP ? 32'hA5A5A5A5 : 32'd8);
    check_all();
    tick();
    Regwrite = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("nrd3_after", rd_vec3[k*32 +: 32], 32'hA5A5A5A5);
    @(negedge Clk);

    // Reset mid-scrub restarts the full sequence; reg 3 overwritten first
    idle_in(); Regwrite = 1'b1; A3 = 5'd3; Wd = 32'hCAFEF00D;
    tick();
    idle_in(); Reset = 1'b1;
    tick();
    for (int e = 0; e < 10; e++) begin idle_in(); check_all(); tick(); end
    idle_in(); Reset = 1'b1;
    tick();
    for (int e = 1; e <= 32; e++) begin
      idle_in();
      tick();
      if (e < 32) chk("restart_ready_low", {31'd0, rdy2}, 32'd0);
      else chk("restart_ready_high", {31'd0, rdy2}, 32'd1);
    end
    idle_in(); ra_m[1] = 5'd3;
    #1;
    chk("restart_reg3", rd_vec2[63:32], 32'd4);
    @(negedge Clk);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      Reset    = ($urandom_range(0, 79) == 0);
      Regwrite = $urandom_range(0, 1) == 1;
      A3       = 5'($urandom_range(0, 31));
      Wd       = $urandom;
      for (int k = 0; k < 2; k++) ra_m[k] = ($urandom_range(0, 2) == 0) ? A3 : 5'($urandom_range(0, 31));
      for (int k = 0; k < 3; k++) ra_n[k] = ($urandom_range(0, 2) == 0) ? A3 : 5'($urandom_range(0, 31));
      check_all();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
